dffrf_nr1w: RTL

- Parametrised flip-flop register file: one synchronous write port, N_READ registered read ports, per-port read enables and write-to-read bypass.
- Optional hardwired-zero entry 0.
- Built-in clear sequencer sweeps every entry to zero after reset or on request.
- Drop-in next generation of the CPU-side 2R1W register file. Also serves as a generic small scratch RAM in SoC peripherals.

---
 rtl/dffrf_nr1w.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dffrf_nr1w.sv
// Flip-flop register file with one write port and N_READ registered read ports.
// A clear sequencer zeroes every entry after reset or on a CLR pulse.
module dffrf_nr1w #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned N_READ   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CLR,
    output logic                       BUSY,
    input  logic                       WE,
    input  logic [ADDR_W-1:0]          RW,
    input  logic [DATA_W-1:0]          DW,
    input  logic [N_READ-1:0]          RE,
    input  logic [N_READ*ADDR_W-1:0]   RA,
    output logic [N_READ*DATA_W-1:0]   DO
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_do  [N_READ];
    logic [DATA_W-1:0]   w_rd  [N_READ];
    logic [ADDR_W-1:0]   w_ra  [N_READ];
    logic                w_wr_ok;

    assign BUSY = (r_state == StInit);

    always_comb begin
        w_wr_ok = (r_state == StRun) && WE && !CLR && ({1'b0, RW} < DEPTH_X);
        if (ZERO_REG != 0 && RW == '0) begin
            w_wr_ok = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StInit;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StInit: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = StRun;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StRun: begin
                if (CLR) begin
                    w_state_nxt = StInit;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = StInit;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage is never reset; the sweep zeroes it before RUN.
    always_ff @(posedge CLK) begin
        if (r_state == StInit) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[RW] <= DW;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N_READ); i++) begin
            w_ra[i] = RA[i*ADDR_W +: ADDR_W];
            w_rd[i] = '0;
            if (ZERO_REG != 0 && w_ra[i] == '0) begin
                w_rd[i] = '0;
            end else if ({1'b0, w_ra[i]} >= DEPTH_X) begin
                w_rd[i] = '0;
            end else if (BYPASS != 0 && w_wr_ok && RW == w_ra[i]) begin
                w_rd[i] = DW;
            end else begin
                w_rd[i] = r_mem[w_ra[i]];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(N_READ); i++) begin
                r_do[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_READ); i++) begin
                if (RE[i]) begin
                    r_do[i] <= (r_state == StInit) ? '0 : w_rd[i];
                end
            end
        end
    end

    always_comb begin
        DO = '0;
        for (int i = 0; i < int'(N_READ); i++) begin
            DO[i*DATA_W +: DATA_W] = r_do[i];
        end
    end

endmodule
